// File: rtl/reward_controller.sv
// rtl/reward_controller.sv - timed reward spawner with protect/slow effects and bonus pulse
module reward_controller #(
  parameter int unsigned SPAWN_TICKS  = 40,
  parameter int unsigned LIFE_TICKS   = 24,
  parameter int unsigned EFFECT_TICKS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [1:0]  game_status,
  input  logic [5:0]  head_x,
  input  logic [5:0]  head_y,
  output logic [5:0]  reward_x,
  output logic [4:0]  reward_y,
  output logic        reward_visible,
  output logic [11:0] VGA_reward,
  output logic        reward_protected,
  output logic        reward_slowly,
  output logic        reward_grade,
  output logic        speedRecover
);

  typedef enum logic [1:0] {IDLE, WAIT_SPAWN, SHOWN, ACTIVE} state_t;

  localparam logic [1:0] T_PROT  = 2'd0;
  localparam logic [1:0] T_SLOW  = 2'd1;
  localparam logic [1:0] T_GRADE = 2'd2;
  localparam logic [7:0] SPAWN_CNT  = 8'(SPAWN_TICKS);
  localparam logic [7:0] LIFE_CNT   = 8'(LIFE_TICKS);
  localparam logic [7:0] EFFECT_CNT = 8'(EFFECT_TICKS);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [5:0]  rx_q, rx_d;
  logic [4:0]  ry_q, ry_d;
  logic [1:0]  type_q, type_d;
  logic        grade_q, grade_d;
  logic        recover_q, recover_d;

  logic [5:0]  spawn_a, spawn_x_raw, spawn_x;
  logic [4:0]  spawn_b, spawn_y;
  logic [1:0]  spawn_type;
  logic        hit, last_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      lfsr_q    <= 16'hACE1;
      rx_q      <= 6'd0;
      ry_q      <= 5'd0;
      type_q    <= T_PROT;
      grade_q   <= 1'b0;
      recover_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      rx_q      <= rx_d;
      ry_q      <= ry_d;
      type_q    <= type_d;
      grade_q   <= grade_d;
      recover_q <= recover_d;
    end
  end

  // Fold the 6/5-bit LFSR fields onto the 1..38 x 1..28 playfield; nudge off the head.
  always_comb begin
    spawn_a     = lfsr_q[5:0];
    spawn_b     = lfsr_q[12:8];
    spawn_x_raw = (spawn_a >= 6'd38) ? spawn_a - 6'd31 : spawn_a + 6'd1;
    spawn_y     = (spawn_b >= 5'd28) ? spawn_b - 5'd15 : spawn_b + 5'd1;
    spawn_x     = spawn_x_raw;
    if (spawn_x_raw == head_x && {1'b0, spawn_y} == head_y) begin
      spawn_x = (spawn_x_raw == 6'd38) ? 6'd1 : spawn_x_raw + 6'd1;
    end
    spawn_type = (lfsr_q[15:14] == 2'b11) ? T_PROT : lfsr_q[15:14];
    hit        = (state_q == SHOWN) && (head_x == rx_q) && (head_y == {1'b0, ry_q});
    last_tick  = tick && (cnt_q == 8'd1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    rx_d      = rx_q;
    ry_d      = ry_q;
    type_d    = type_q;
    grade_d   = 1'b0;
    recover_d = 1'b0;
    if (game_status != 2'b10) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
      rx_d    = 6'd0;
      ry_d    = 5'd0;
      type_d  = T_PROT;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_SPAWN;
          cnt_d   = SPAWN_CNT;
        end
        WAIT_SPAWN: begin
          if (last_tick) begin
            state_d = SHOWN;
            cnt_d   = LIFE_CNT;
            rx_d    = spawn_x;
            ry_d    = spawn_y;
            type_d  = spawn_type;
          end else if (tick) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        SHOWN: begin
          if (hit) begin
            if (type_q == T_GRADE) begin
              grade_d = 1'b1;
              state_d = WAIT_SPAWN;
              cnt_d   = SPAWN_CNT;
            end else begin
              state_d = ACTIVE;
              cnt_d   = EFFECT_CNT;
            end
          end else if (last_tick) begin
            state_d = WAIT_SPAWN;
            cnt_d   = SPAWN_CNT;
          end else if (tick) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ACTIVE: begin
          if (last_tick) begin
            state_d   = WAIT_SPAWN;
            cnt_d     = SPAWN_CNT;
            recover_d = (type_q == T_SLOW);
          end else if (tick) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    reward_x         = rx_q;
    reward_y         = ry_q;
    reward_visible   = (state_q == SHOWN);
    VGA_reward       = 12'h000;
    if (state_q == SHOWN) begin
      case (type_q)
        T_PROT:  VGA_reward = 12'h0FF;
        T_SLOW:  VGA_reward = 12'h00F;
        T_GRADE: VGA_reward = 12'hFF0;
        default: VGA_reward = 12'h000;
      endcase
    end
    reward_protected = (state_q == ACTIVE) && (type_q == T_PROT);
    reward_slowly    = (state_q == ACTIVE) && (type_q == T_SLOW);
    reward_grade     = grade_q;
    speedRecover     = recover_q;
  end

endmodule

// File: tb/tb_reward_controller.sv
// tb/tb_reward_controller.sv - scoreboard bench for reward_controller
module tb_reward_controller;

  logic        clk;
  logic        rst;
  logic        tick;
  logic [1:0]  game_status;
  logic [5:0]  head_x;
  logic [5:0]  head_y;
  logic [5:0]  reward_x;
  logic [4:0]  reward_y;
  logic        reward_visible;
  logic [11:0] VGA_reward;
  logic        reward_protected;
  logic        reward_slowly;
  logic        reward_grade;
  logic        speedRecover;

  reward_controller #(
    .SPAWN_TICKS(2),
    .LIFE_TICKS(3),
    .EFFECT_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .game_status(game_status),
    .head_x(head_x),
    .head_y(head_y),
    .reward_x(reward_x),
    .reward_y(reward_y),
    .reward_visible(reward_visible),
    .VGA_reward(VGA_reward),
    .reward_protected(reward_protected),
    .reward_slowly(reward_slowly),
    .reward_grade(reward_grade),
    .speedRecover(speedRecover)
  );

  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
    logic [1:0] t;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          grade_cnt = 0;
  int          rec_cnt = 0;
  logic [15:0] m_lfsr;
  logic [5:0]  last_x;
  logic [4:0]  last_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  always @(negedge clk) begin
    if (reward_grade) grade_cnt++;
    if (speedRecover) rec_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void predict(input logic [15:0] l, input logic [5:0] hx, input logic [5:0] hy,
                                  output logic [5:0] x, output logic [4:0] y, output logic [1:0] t);
    logic [5:0] a;
    logic [4:0] b;
    a = l[5:0];
    b = l[12:8];
    x = (a >= 6'd38) ? a - 6'd31 : a + 6'd1;
    y = (b >= 5'd28) ? b - 5'd15 : b + 5'd1;
    if (x == hx && {1'b0, y} == hy) x = (x == 6'd38) ? 6'd1 : x + 6'd1;
    t = (l[15:14] == 2'b11) ? 2'b00 : l[15:14];
  endfunction

  function automatic logic [11:0] color(input logic [1:0] t);
    case (t)
      2'd0:    return 12'h0FF;
      2'd1:    return 12'h00F;
      2'd2:    return 12'hFF0;
      default: return 12'h000;
    endcase
  endfunction

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic check_spawn();
    exp_t e;
    chk("spawn_vis", 32'(reward_visible), 1);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      chk("spawn_x", 32'(reward_x), 32'(e.x));
      chk("spawn_y", 32'(reward_y), 32'(e.y));
      chk("spawn_vga", 32'(VGA_reward), 32'(color(e.t)));
      chk("x_range", 32'(reward_x >= 6'd1 && reward_x <= 6'd38), 1);
      chk("y_range", 32'(reward_y >= 5'd1 && reward_y <= 5'd28), 1);
      last_x = e.x;
      last_y = e.y;
    end
  endtask

  // Starts in WAIT_SPAWN with a full count; want < 0 accepts any type.
  task automatic spawn(input int want);
    int n;
    exp_t e;
    cyc(1'b1);
    chk("pre_spawn_vis", 32'(reward_visible), 0);
    n = 0;
    predict(m_lfsr, head_x, head_y, e.x, e.y, e.t);
    while (want >= 0 && e.t != want[1:0] && n < 400) begin
      cyc(1'b0);
      n++;
      predict(m_lfsr, head_x, head_y, e.x, e.y, e.t);
    end
    if (want >= 0) chk("type_wait", 32'(e.t == want[1:0]), 1);
    exp_q.push_back(e);
    cyc(1'b1);
    check_spawn();
  endtask

  task automatic head_on();
    head_x = last_x;
    head_y = {1'b0, last_y};
  endtask

  task automatic head_off();
    head_x = 6'd0;
    head_y = 6'd0;
  endtask

  initial begin
    int   n;
    exp_t e;
    rst = 1'b1;
    tick = 1'b0;
    game_status = 2'b00;
    head_x = 6'd0;
    head_y = 6'd0;
    last_x = 6'd0;
    last_y = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vis", 32'(reward_visible), 0);
    chk("rst_x", 32'(reward_x), 0);
    chk("rst_y", 32'(reward_y), 0);
    chk("rst_vga", 32'(VGA_reward), 0);
    chk("rst_prot", 32'(reward_protected), 0);
    chk("rst_slow", 32'(reward_slowly), 0);
    chk("rst_grade", 32'(reward_grade), 0);
    chk("rst_rec", 32'(speedRecover), 0);
    rst = 1'b0;

    // first spawn
    game_status = 2'b10;
    cyc(1'b0);
    spawn(-1);

    // expiry without hit
    cyc(1'b1);
    chk("exp_vis1", 32'(reward_visible), 1);
    cyc(1'b1);
    chk("exp_vis2", 32'(reward_visible), 1);
    cyc(1'b1);
    chk("exp_vis3", 32'(reward_visible), 0);
    chk("exp_vga", 32'(VGA_reward), 0);
    chk("exp_grade_cnt", 32'(grade_cnt), 0);
    chk("exp_rec_cnt", 32'(rec_cnt), 0);

    // slowly effect, hit between ticks
    spawn(1);
    head_on();
    cyc(1'b0);
    chk("slow_on", 32'(reward_slowly), 1);
    chk("slow_vis", 32'(reward_visible), 0);
    chk("slow_prot", 32'(reward_protected), 0);
    head_off();
    cyc(1'b1);
    chk("slow_mid", 32'(reward_slowly), 1);
    chk("slow_mid_rec", 32'(speedRecover), 0);
    cyc(1'b1);
    chk("slow_off", 32'(reward_slowly), 0);
    chk("slow_rec", 32'(speedRecover), 1);
    cyc(1'b0);
    chk("slow_rec_end", 32'(speedRecover), 0);
    chk("slow_rec_cnt", 32'(rec_cnt), 1);

    // grade hit
    spawn(2);
    head_on();
    cyc(1'b0);
    chk("grade_pulse", 32'(reward_grade), 1);
    chk("grade_vis", 32'(reward_visible), 0);
    chk("grade_prot", 32'(reward_protected), 0);
    chk("grade_slow", 32'(reward_slowly), 0);
    head_off();
    cyc(1'b0);
    chk("grade_end", 32'(reward_grade), 0);
    chk("grade_cnt", 32'(grade_cnt), 1);

    // hit and expiry on the same tick resolve as hit
    spawn(0);
    cyc(1'b1);
    cyc(1'b1);
    chk("he_vis", 32'(reward_visible), 1);
    head_on();
    cyc(1'b1);
    chk("he_prot", 32'(reward_protected), 1);
    chk("he_vis_off", 32'(reward_visible), 0);
    head_off();

    // abort protected effect, then re-enter play
    game_status = 2'b11;
    cyc(1'b1);
    chk("abort_prot", 32'(reward_protected), 0);
    chk("abort_rec", 32'(speedRecover), 0);
    chk("abort_x", 32'(reward_x), 0);
    game_status = 2'b10;
    cyc(1'b0);
    spawn(-1);
    chk("abort_rec_cnt", 32'(rec_cnt), 1);
    chk("abort_grade_cnt", 32'(grade_cnt), 1);

    // spawn onto head at x=38 wraps to x=1
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    chk("wrap_pre_vis", 32'(reward_visible), 0);
    cyc(1'b1);
    n = 0;
    while (m_lfsr[5:0] != 6'd37 && n < 3000) begin
      cyc(1'b0);
      n++;
    end
    chk("wrap_wait", 32'(m_lfsr[5:0] == 6'd37), 1);
    head_x = 6'd38;
    head_y = {1'b0, (m_lfsr[12:8] >= 5'd28) ? m_lfsr[12:8] - 5'd15 : m_lfsr[12:8] + 5'd1};
    predict(m_lfsr, head_x, head_y, e.x, e.y, e.t);
    exp_q.push_back(e);
    cyc(1'b1);
    check_spawn();
    chk("wrap_x", 32'(reward_x), 1);

    // reset while shown
    rst = 1'b1;
    cyc(1'b0);
    chk("rs_vis", 32'(reward_visible), 0);
    chk("rs_x", 32'(reward_x), 0);
    chk("rs_y", 32'(reward_y), 0);
    chk("rs_vga", 32'(VGA_reward), 0);
    chk("rs_prot", 32'(reward_protected), 0);
    chk("rs_slow", 32'(reward_slowly), 0);
    chk("rs_grade", 32'(reward_grade), 0);
    chk("rs_rec", 32'(speedRecover), 0);
    rst = 1'b0;
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
